hid_report_decoder: RTL and testbench

Upstream stage of the keyboard path. It accepts 8-byte USB HID boot-protocol keyboard reports, byte-serially, from the USB host side. It compares each complete report against the last committed report and emits one key event per change (modifier change, key release, key press) over a valid/ready handshake. The downstream keycode/I2C transmit path consumes these events.

---
 rtl/hid_report_decoder.sv | 186 ++++++++++++++++++
 tb/tb_hid_report_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hid_report_decoder.sv
// hid_report_decoder
// Collects 8-byte HID boot-protocol keyboard reports byte-serially, compares
// each complete report against the last committed one, and emits one event per
// change (modifier, releases in old-slot order, presses in new-slot order)
// over a valid/ready handshake. Reports carrying ErrorRollOver are discarded
// and counted.
module hid_report_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rpt_data,
   input  logic       rpt_valid,
   input  logic       rpt_first,
   output logic       rpt_ready,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic       ev_is_mod,
   output logic       ev_press,
   output logic [7:0] ev_code,
   output logic [7:0] rollover_cnt
);

   localparam int KEYS = 6;

   localparam logic [2:0] S_COLLECT = 3'd0;
   localparam logic [2:0] S_CHECK   = 3'd1;
   localparam logic [2:0] S_MOD     = 3'd2;
   localparam logic [2:0] S_REL     = 3'd3;
   localparam logic [2:0] S_PRS     = 3'd4;
   localparam logic [2:0] S_COMMIT  = 3'd5;

   localparam logic [7:0] KC_NONE     = 8'h00;
   localparam logic [7:0] KC_ROLLOVER = 8'h01;

   logic [2:0]            state;
   logic [2:0]            byte_cnt;
   logic [2:0]            slot;
   logic [7:0]            new_mod;
   logic [7:0]            old_mod;
   logic [KEYS-1:0][7:0]  new_keys;
   logic [KEYS-1:0][7:0]  old_keys;

   logic       accept;
   logic       last_slot;
   logic       handshake;
   logic [7:0] cur_old;
   logic [7:0] cur_new;
   logic       rel_hit;
   logic       prs_hit;

   // True when code appears in any of the six slots of set.
   function automatic logic in_set(input logic [7:0] code,
                                   input logic [KEYS-1:0][7:0] set);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < KEYS; k++)
         if (set[k] == code) hit = 1'b1;
      return hit;
   endfunction

   // True when code already appears in a slot below idx (duplicate suppression).
   function automatic logic seen_before(input logic [7:0] code,
                                        input logic [KEYS-1:0][7:0] set,
                                        input logic [2:0] idx);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < KEYS; k++)
         if ((3'(k) < idx) && (set[k] == code)) hit = 1'b1;
      return hit;
   endfunction

   assign rpt_ready = (state == S_COLLECT);
   assign accept    = rpt_valid && rpt_ready;
   assign last_slot = (slot == 3'(KEYS - 1));
   assign handshake = ev_valid && ev_ready;

   // Slot select and per-slot release/press decisions for the scan.
   always_comb begin
      cur_old = KC_NONE;
      cur_new = KC_NONE;
      for (int k = 0; k < KEYS; k++) begin
         if (slot == 3'(k)) begin
            cur_old = old_keys[k];
            cur_new = new_keys[k];
         end
      end
      rel_hit = (cur_old != KC_NONE) &&
                !in_set(cur_old, new_keys) &&
                !seen_before(cur_old, old_keys, slot);
      prs_hit = (cur_new != KC_NONE) && (cur_new != KC_ROLLOVER) &&
                !in_set(cur_new, old_keys) &&
                !seen_before(cur_new, new_keys, slot);
   end

   // Incoming report store: byte 0 is the modifier byte, bytes 2..7 the keys.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (rpt_first) begin
            new_mod <= rpt_data;
         end else begin
            for (int k = 0; k < KEYS; k++)
               if (byte_cnt == 3'(k + 2)) new_keys[k] <= rpt_data;
         end
      end
   end

   // Control FSM, event registers, rollover counter and committed-report store.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_COLLECT;
         byte_cnt     <= 3'd0;
         slot         <= 3'd0;
         old_mod      <= KC_NONE;
         old_keys     <= '0;
         ev_valid     <= 1'b0;
         ev_is_mod    <= 1'b0;
         ev_press     <= 1'b0;
         ev_code      <= 8'h00;
         rollover_cnt <= 8'h00;
      end else begin
         case (state)
            S_COLLECT: begin
               if (accept) begin
                  if (rpt_first) begin
                     byte_cnt <= 3'd1;
                  end else if (byte_cnt != 3'd0) begin
                     byte_cnt <= byte_cnt + 3'd1;
                     if (byte_cnt == 3'd7) state <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               if (in_set(KC_ROLLOVER, new_keys)) begin
                  if (rollover_cnt != 8'hFF) rollover_cnt <= rollover_cnt + 8'd1;
                  byte_cnt <= 3'd0;
                  state    <= S_COLLECT;
               end else begin
                  state <= S_MOD;
               end
            end
            S_MOD: begin
               if (ev_valid) begin
                  if (handshake) begin
                     ev_valid <= 1'b0;
                     slot     <= 3'd0;
                     state    <= S_REL;
                  end
               end else if (new_mod != old_mod) begin
                  ev_valid  <= 1'b1;
                  ev_is_mod <= 1'b1;
                  ev_press  <= 1'b0;
                  ev_code   <= new_mod;
               end else begin
                  slot  <= 3'd0;
                  state <= S_REL;
               end
            end
            S_REL, S_PRS: begin
               if (ev_valid && !handshake) begin
                  // hold the presented event until downstream takes it
               end else if (!ev_valid && (state == S_REL ? rel_hit : prs_hit)) begin
                  ev_valid  <= 1'b1;
                  ev_is_mod <= 1'b0;
                  ev_press  <= (state == S_PRS);
                  ev_code   <= (state == S_REL) ? cur_old : cur_new;
               end else begin
                  ev_valid <= 1'b0;
                  if (last_slot) begin
                     slot  <= 3'd0;
                     state <= (state == S_REL) ? S_PRS : S_COMMIT;
                  end else begin
                     slot <= slot + 3'd1;
                  end
               end
            end
            S_COMMIT: begin
               old_mod  <= new_mod;
               old_keys <= new_keys;
               byte_cnt <= 3'd0;
               state    <= S_COLLECT;
            end
            default: state <= S_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_hid_report_decoder.sv
// Directed testbench for hid_report_decoder: a table of reports with
// hand-computed event lists and scan lengths, plus hand-written sequences for
// resync, abandoned reports, rollover saturation and a stalled event cut by reset.
module tb_hid_report_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rpt_data;
   logic       rpt_valid;
   logic       rpt_first;
   logic       rpt_ready;
   logic       ev_valid;
   logic       ev_ready;
   logic       ev_is_mod;
   logic       ev_press;
   logic [7:0] ev_code;
   logic [7:0] rollover_cnt;

   hid_report_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .rpt_data     (rpt_data),
      .rpt_valid    (rpt_valid),
      .rpt_first    (rpt_first),
      .rpt_ready    (rpt_ready),
      .ev_valid     (ev_valid),
      .ev_ready     (ev_ready),
      .ev_is_mod    (ev_is_mod),
      .ev_press     (ev_press),
      .ev_code      (ev_code),
      .rollover_cnt (rollover_cnt)
   );

   always #5 clk = ~clk;

   // Event encoding {is_mod, press, code}: press=10'h1xx, release=10'h0xx, mod=10'h2xx.
   typedef struct {
      logic [63:0] bytes;   // byte 0 in [63:56]
      int          n;       // expected event count
      logic [39:0] evs;     // up to 4 events, first in [39:30]
      int          cyc;     // cycles from CHECK until rpt_ready is back
      int          roll;    // expected rollover_cnt afterwards
   } vec_t;

   int         n_checks = 0;
   int         n_err    = 0;
   logic [9:0] got_ev [8];
   int         got_n;
   int         got_cycles;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      rpt_valid = 1'b0;
      rpt_first = 1'b0;
      rpt_data  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic first);
      rpt_valid = 1'b1;
      rpt_first = first;
      rpt_data  = d;
      @(posedge clk);
      #1;
      rpt_valid = 1'b0;
      rpt_first = 1'b0;
   endtask

   // Sends a full report and records events until the block is ready again.
   task automatic run_report(input logic [63:0] bytes);
      for (int k = 0; k < 8; k++)
         send_byte(bytes[63-8*k -: 8], (k == 0));
      got_n      = 0;
      got_cycles = 0;
      while (!rpt_ready && got_cycles < 300) begin
         if (ev_valid && ev_ready) begin
            if (got_n < 8) got_ev[got_n] = {ev_is_mod, ev_press, ev_code};
            got_n++;
         end
         @(posedge clk);
         #1;
         got_cycles++;
      end
      if (!rpt_ready) chk("scan_timeout", 64'(got_cycles), 64'd0);
   endtask

   task automatic expect_events(input string name, input int n, input logic [39:0] evs);
      chk({name, "_count"}, 64'(got_n), 64'(n));
      for (int k = 0; k < 4; k++)
         if (k < n && k < got_n)
            chk($sformatf("%s_ev%0d", name, k), 64'(got_ev[k]), 64'(evs[39-10*k -: 10]));
   endtask

   vec_t vecs [9];
   logic [9:0] held;

   initial begin
      ev_ready = 1'b1;
      vecs[0] = '{64'h0000_0400_0000_0000, 1, {10'h104, 30'h0}, 16, 0};
      vecs[1] = '{64'h0200_0504_0000_0000, 2, {10'h202, 10'h105, 20'h0}, 17, 0};
      vecs[2] = '{64'h0200_0405_0000_0000, 0, 40'h0, 15, 0};
      vecs[3] = '{64'h0200_0000_0000_0000, 2, {10'h004, 10'h005, 20'h0}, 17, 0};
      vecs[4] = '{64'h0000_0101_0101_0101, 0, 40'h0, 1, 1};
      vecs[5] = '{64'h0200_0600_0000_0000, 1, {10'h106, 30'h0}, 16, 1};
      vecs[6] = '{64'h0200_0607_0700_0000, 1, {10'h107, 30'h0}, 16, 1};
      vecs[7] = '{64'h0200_0000_0000_0000, 2, {10'h006, 10'h007, 20'h0}, 17, 1};
      vecs[8] = '{64'h1100_0809_0000_0000, 3, {10'h211, 10'h108, 10'h109, 10'h0}, 18, 1};

      do_reset();
      chk("rst_rpt_ready", 64'(rpt_ready), 64'd1);
      chk("rst_ev_valid", 64'(ev_valid), 64'd0);
      chk("rst_fields", 64'({ev_is_mod, ev_press, ev_code}), 64'd0);
      chk("rst_rollover", 64'(rollover_cnt), 64'd0);

      // Table of reports applied back to back; each depends on the previous commit.
      for (int v = 0; v < 9; v++) begin
         run_report(vecs[v].bytes);
         expect_events($sformatf("vec%0d", v), vecs[v].n, vecs[v].evs);
         chk($sformatf("vec%0d_cycles", v), 64'(got_cycles), 64'(vecs[v].cyc));
         chk($sformatf("vec%0d_rollover", v), 64'(rollover_cnt), 64'(vecs[v].roll));
      end

      // Rollover saturation: 256 rollover reports in total.
      for (int r = 0; r < 255; r++) begin
         run_report(64'h0000_0101_0101_0101);
         if (r == 253) chk("rollover_255th", 64'(rollover_cnt), 64'd255);
      end
      chk("rollover_sat", 64'(rollover_cnt), 64'd255);
      chk("rollover_no_events", 64'(got_n), 64'd0);

      // Bytes without rpt_first right after reset are dropped.
      do_reset();
      for (int k = 0; k < 8; k++)
         send_byte((k == 2) ? 8'h04 : 8'h00, 1'b0);
      chk("resync_ready", 64'(rpt_ready), 64'd1);
      chk("resync_no_ev", 64'(ev_valid), 64'd0);
      run_report(64'h0000_0400_0000_0000);
      expect_events("resync_next", 1, {10'h104, 30'h0});

      // Partial report abandoned by a new rpt_first.
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b0);
      send_byte(8'h04, 1'b0);
      run_report(64'h0000_0700_0000_0000);
      expect_events("abandon", 1, {10'h107, 30'h0});

      // Press held with ev_ready low, then reset mid-scan.
      ev_ready = 1'b0;
      for (int k = 0; k < 8; k++)
         send_byte((k == 2) ? 8'h07 : (k == 3) ? 8'h04 : 8'h00, (k == 0));
      got_cycles = 0;
      while (!ev_valid && got_cycles < 40) begin
         @(posedge clk);
         #1;
         got_cycles++;
      end
      held = {ev_is_mod, ev_press, ev_code};
      chk("stall_event", 64'(held), 64'h104);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall_c%0d", c),
             64'({ev_valid, rpt_ready, ev_is_mod, ev_press, ev_code}),
             64'({1'b1, 1'b0, held}));
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_ev_valid", 64'(ev_valid), 64'd0);
      chk("midrst_fields", 64'({ev_is_mod, ev_press, ev_code}), 64'd0);
      chk("midrst_ready", 64'(rpt_ready), 64'd1);
      rst = 1'b0;
      ev_ready = 1'b1;
      run_report(64'h0000_0400_0000_0000);
      expect_events("after_rst", 1, {10'h104, 30'h0});
      chk("after_rst_cycles", 64'(got_cycles), 64'd16);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
